rr_priority_arbiter: RTL and testbench

- Round-robin arbiter sharing one downstream resource among 128 level-sensitive requesters.
- Built around the 128-to-7 highest-index-wins priority encoder datapath; adds a rotating priority pointer, a registered grant, a valid/ready grant handshake, and a lock held until the winner releases.
- Sits between the request vector and the shared resource.

---
 rtl/rr_priority_arbiter.sv | 168 ++++++++++++++++
 tb/tb_rr_priority_arbiter.sv | 295 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rr_priority_arbiter.sv
// rr_priority_arbiter: round-robin arbiter sharing one downstream resource
// among N level-sensitive requesters. A rotating pointer masks off requests
// at or above the last accepted index so that lower requesters get a turn.
// Each grant is offered with a valid/ready handshake and then locked until
// the owner pulses rel.
// Optional feature macro: ARB_LOCK_TIMEOUT_EN (forced release after TIMEOUT
// BUSY cycles without rel, signalled by a one-cycle timeout_evt pulse).
module rr_priority_arbiter #(
    parameter int N       = 128,
    parameter int IW      = 7,
    parameter int CNT_W   = 16,
    parameter int TIMEOUT = 1024
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [N-1:0]     req,
    input  logic             gnt_ready,
    input  logic             rel,
    output logic             gnt_valid,
    output logic [IW-1:0]    gnt_idx,
    output logic             gnt_busy,
    output logic [CNT_W-1:0] gnt_cnt,
    output logic             timeout_evt
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_OFFER = 2'd1,
        ST_BUSY  = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [IW-1:0]      ptr_q, ptr_d;
    logic               gntValid_q, gntValid_d;
    logic [IW-1:0]      gntIdx_q, gntIdx_d;
    logic               gntBusy_q, gntBusy_d;
    logic [CNT_W-1:0]   gntCnt_q, gntCnt_d;

    logic [IW-1:0]      winMasked;
    logic [IW-1:0]      winAll;
    logic               anyMasked;
    logic [IW-1:0]      winner;

`ifdef ARB_LOCK_TIMEOUT_EN
    localparam int TO_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    logic [TO_W-1:0]    busyCnt_q, busyCnt_d;
    logic               timeoutEvt_q, timeoutEvt_d;
`else
    // Without the forced-release feature TIMEOUT has no effect; degenerate
    // values are accepted and nothing is elaborated for them.
    if (TIMEOUT < 2) begin : gTimeoutDegenerate
    end
`endif

    // Priority encoder: highest request strictly below the pointer wins, else highest overall.
    always_comb begin
        winMasked = '0;
        winAll    = '0;
        anyMasked = 1'b0;
        for (int i = 0; i < N; i++) begin
            if (req[i]) begin
                winAll = IW'(i);
                if (i < int'(ptr_q)) begin
                    winMasked = IW'(i);
                    anyMasked = 1'b1;
                end
            end
        end
        winner = anyMasked ? winMasked : winAll;
    end

    // Next-state logic for the IDLE -> OFFER -> BUSY -> IDLE grant cycle.
    always_comb begin
        state_d    = state_q;
        ptr_d      = ptr_q;
        gntValid_d = gntValid_q;
        gntIdx_d   = gntIdx_q;
        gntBusy_d  = gntBusy_q;
        gntCnt_d   = gntCnt_q;
`ifdef ARB_LOCK_TIMEOUT_EN
        busyCnt_d    = busyCnt_q;
        timeoutEvt_d = 1'b0;
`endif
        unique case (state_q)
            ST_IDLE: begin
                if (req != '0) begin
                    gntIdx_d   = winner;
                    gntValid_d = 1'b1;
                    state_d    = ST_OFFER;
                end
            end
            ST_OFFER: begin
                if (gnt_ready) begin
                    ptr_d      = gntIdx_q;
                    gntCnt_d   = (gntCnt_q == '1) ? gntCnt_q : gntCnt_q + CNT_W'(1);
                    gntValid_d = 1'b0;
                    gntBusy_d  = 1'b1;
                    state_d    = ST_BUSY;
`ifdef ARB_LOCK_TIMEOUT_EN
                    busyCnt_d  = '0;
`endif
                end
            end
            ST_BUSY: begin
                if (rel) begin
                    gntBusy_d = 1'b0;
                    state_d   = ST_IDLE;
                end
`ifdef ARB_LOCK_TIMEOUT_EN
                else if (busyCnt_q == TO_W'(TIMEOUT - 1)) begin
                    timeoutEvt_d = 1'b1;
                    gntBusy_d    = 1'b0;
                    state_d      = ST_IDLE;
                end else begin
                    busyCnt_d = busyCnt_q + TO_W'(1);
                end
`endif
            end
            default: begin
                state_d    = ST_IDLE;
                gntValid_d = 1'b0;
                gntBusy_d  = 1'b0;
            end
        endcase
    end

    // State and output registers, cleared asynchronously by rst_n.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            ptr_q      <= '0;
            gntValid_q <= 1'b0;
            gntIdx_q   <= '0;
            gntBusy_q  <= 1'b0;
            gntCnt_q   <= '0;
        end else begin
            state_q    <= state_d;
            ptr_q      <= ptr_d;
            gntValid_q <= gntValid_d;
            gntIdx_q   <= gntIdx_d;
            gntBusy_q  <= gntBusy_d;
            gntCnt_q   <= gntCnt_d;
        end
    end

`ifdef ARB_LOCK_TIMEOUT_EN
    // BUSY-cycle counter and the registered forced-release pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busyCnt_q    <= '0;
            timeoutEvt_q <= 1'b0;
        end else begin
            busyCnt_q    <= busyCnt_d;
            timeoutEvt_q <= timeoutEvt_d;
        end
    end

    assign timeout_evt = timeoutEvt_q;
`else
    assign timeout_evt = 1'b0;
`endif

    assign gnt_valid = gntValid_q;
    assign gnt_idx   = gntIdx_q;
    assign gnt_busy  = gntBusy_q;
    assign gnt_cnt   = gntCnt_q;

endmodule

// File: tb/tb_rr_priority_arbiter.sv
// Testbench for rr_priority_arbiter: directed scenarios followed by random
// request/ready/release traffic, all compared cycle by cycle with a
// behavioural model of the arbitration rules. Built with TIMEOUT=8 so the
// ARB_LOCK_TIMEOUT_EN build can be exercised in a short run.
module tb_rr_priority_arbiter;

    localparam int N       = 128;
    localparam int IW      = 7;
    localparam int CNT_W   = 16;
    localparam int TIMEOUT = 8;

    logic             clk;
    logic             rst_n;
    logic [N-1:0]     req;
    logic             gnt_ready;
    logic             rel;
    logic             gnt_valid;
    logic [IW-1:0]    gnt_idx;
    logic             gnt_busy;
    logic [CNT_W-1:0] gnt_cnt;
    logic             timeout_evt;

    int testsRun;
    int testsFailed;

    // Behavioural model state: phase 0 = idle, 1 = offering, 2 = locked.
    int mPhase;
    int mPtr;
    int mIdx;
    int mValid;
    int mBusy;
    int mCnt;
    int mTimeout;
    int mBusyCycles;

    rr_priority_arbiter #(
        .N(N), .IW(IW), .CNT_W(CNT_W), .TIMEOUT(TIMEOUT)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .req(req),
        .gnt_ready(gnt_ready),
        .rel(rel),
        .gnt_valid(gnt_valid),
        .gnt_idx(gnt_idx),
        .gnt_busy(gnt_busy),
        .gnt_cnt(gnt_cnt),
        .timeout_evt(timeout_evt)
    );

    // Free-running clock, 10 time units per period.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        testsRun++;
        if (observed !== expected) begin
            testsFailed++;
            $display("[TB] FAIL %s: observed %0d, expected %0d at time %0t", tag, observed, expected, $time);
        end
    endtask

    // Round-robin choice: nearest requester below the pointer, scanning down;
    // if there is none, wrap to the highest requester overall.
    function automatic int pickWinner(input logic [N-1:0] r, input int ptr);
        for (int i = ptr - 1; i >= 0; i--)
            if (r[i]) return i;
        for (int i = N - 1; i >= 0; i--)
            if (r[i]) return i;
        return -1;
    endfunction

    task automatic modelReset();
        mPhase = 0; mPtr = 0; mIdx = 0; mValid = 0;
        mBusy = 0; mCnt = 0; mTimeout = 0; mBusyCycles = 0;
    endtask

    task automatic modelStep();
        mTimeout = 0;
        case (mPhase)
            0: begin
                if (req != '0) begin
                    mIdx = pickWinner(req, mPtr);
                    mValid = 1;
                    mPhase = 1;
                end
            end
            1: begin
                if (gnt_ready) begin
                    mPtr = mIdx;
                    if (mCnt < (1 << CNT_W) - 1) mCnt = mCnt + 1;
                    mValid = 0;
                    mBusy = 1;
                    mPhase = 2;
                    mBusyCycles = 0;
                end
            end
            default: begin
                if (rel) begin
                    mBusy = 0;
                    mPhase = 0;
                end
`ifdef ARB_LOCK_TIMEOUT_EN
                else if (mBusyCycles == TIMEOUT - 1) begin
                    mTimeout = 1;
                    mBusy = 0;
                    mPhase = 0;
                end else begin
                    mBusyCycles++;
                end
`endif
            end
        endcase
    endtask

    task automatic compareAll();
        checkOutput("gnt_valid", 32'(gnt_valid), 32'(mValid));
        checkOutput("gnt_idx", 32'(gnt_idx), 32'(mIdx));
        checkOutput("gnt_busy", 32'(gnt_busy), 32'(mBusy));
        checkOutput("gnt_cnt", 32'(gnt_cnt), 32'(mCnt));
        checkOutput("timeout_evt", 32'(timeout_evt), 32'(mTimeout));
    endtask

    // One clock: model samples the same inputs as the DUT, outputs are checked 1 unit later.
    task automatic applyStimulus();
        @(posedge clk);
        modelStep();
        #1;
        compareAll();
    endtask

    // Asynchronous reset pulse placed away from the clock edge.
    task automatic asyncReset();
        #2;
        rst_n = 1'b0;
        #1;
        modelReset();
        compareAll();
        req = '0; gnt_ready = 1'b0; rel = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    function automatic logic [N-1:0] randomReq();
        logic [N-1:0] r;
        r = '0;
        case ($urandom_range(0, 3))
            0: r = '0;
            1: r[$urandom_range(0, N - 1)] = 1'b1;
            2: for (int k = 0; k < 3; k++) r[$urandom_range(0, N - 1)] = 1'b1;
            default: r = {$urandom, $urandom, $urandom, $urandom};
        endcase
        return r;
    endfunction

    initial begin
        int expRot[4];
        int pulseAt;
        int pulses;

        testsRun = 0;
        testsFailed = 0;
        rst_n = 1'b0;
        req = '0;
        gnt_ready = 1'b0;
        rel = 1'b0;
        modelReset();
        #3;
        compareAll();
        @(negedge clk);
        rst_n = 1'b1;

        // Rotation between requesters 127 and 5.
        expRot[0] = 127; expRot[1] = 5; expRot[2] = 127; expRot[3] = 5;
        req = '0; req[127] = 1'b1; req[5] = 1'b1;
        gnt_ready = 1'b1;
        for (int g = 0; g < 4; g++) begin
            applyStimulus();
            checkOutput("rotIdx", 32'(gnt_idx), 32'(expRot[g]));
            applyStimulus();
            applyStimulus();
            rel = 1'b1;
            applyStimulus();
            rel = 1'b0;
        end
        checkOutput("rotCnt", 32'(gnt_cnt), 32'd4);

        // Lone low requester, then pointer at 0 lets requester 64 win.
        asyncReset();
        req = '0; req[0] = 1'b1; gnt_ready = 1'b1;
        applyStimulus();
        checkOutput("lowValid", 32'(gnt_valid), 32'd1);
        checkOutput("lowIdx", 32'(gnt_idx), 32'd0);
        applyStimulus();
        req = '0;
        rel = 1'b1;
        applyStimulus();
        rel = 1'b0;
        req[64] = 1'b1;
        applyStimulus();
        checkOutput("idx64", 32'(gnt_idx), 32'd64);

        // Backpressure with the request withdrawn while the offer is pending.
        asyncReset();
        req = '0; req[33] = 1'b1; gnt_ready = 1'b0;
        applyStimulus();
        for (int c = 0; c < 10; c++) begin
            if (c == 3) req = '0;
            applyStimulus();
            checkOutput("bpValid", 32'(gnt_valid), 32'd1);
            checkOutput("bpIdx", 32'(gnt_idx), 32'd33);
        end
        gnt_ready = 1'b1;
        applyStimulus();
        checkOutput("bpBusy", 32'(gnt_busy), 32'd1);

        // Spurious rel in IDLE/OFFER and ready in BUSY are ignored.
        asyncReset();
        rel = 1'b1;
        applyStimulus();
        checkOutput("spIdleValid", 32'(gnt_valid), 32'd0);
        req = '0; req[20] = 1'b1;
        applyStimulus();
        applyStimulus();
        checkOutput("spOfferValid", 32'(gnt_valid), 32'd1);
        rel = 1'b0; gnt_ready = 1'b1;
        applyStimulus();
        gnt_ready = 1'b0;
        applyStimulus();
        gnt_ready = 1'b1;
        applyStimulus();
        applyStimulus();
        checkOutput("spBusyCnt", 32'(gnt_cnt), 32'd1);
        checkOutput("spBusy", 32'(gnt_busy), 32'd1);
        gnt_ready = 1'b0;

        // Asynchronous reset while requester 90 holds the lock.
        asyncReset();
        req = '0; req[90] = 1'b1; gnt_ready = 1'b1;
        applyStimulus();
        applyStimulus();
        checkOutput("rstBusyIdx", 32'(gnt_idx), 32'd90);
        asyncReset();
        checkOutput("rstIdx", 32'(gnt_idx), 32'd0);
        checkOutput("rstBusy", 32'(gnt_busy), 32'd0);
        req = '0; req[90] = 1'b1; req[10] = 1'b1;
        applyStimulus();
        checkOutput("postRstIdx", 32'(gnt_idx), 32'd90);

        // Lock held with no release: forced release or indefinite BUSY.
        asyncReset();
        req = '0; req[7] = 1'b1; gnt_ready = 1'b1;
        applyStimulus();
        applyStimulus();
        req = '0; gnt_ready = 1'b0;
        pulseAt = 0;
        pulses = 0;
`ifdef ARB_LOCK_TIMEOUT_EN
        for (int k = 1; k <= 20; k++) begin
            applyStimulus();
            if (timeout_evt) begin
                pulses++;
                if (pulseAt == 0) pulseAt = k;
            end
        end
        checkOutput("toPulseAt", 32'(pulseAt), 32'd8);
        checkOutput("toPulses", 32'(pulses), 32'd1);
        checkOutput("toBusy", 32'(gnt_busy), 32'd0);
        req[3] = 1'b1;
        applyStimulus();
        checkOutput("toRearb", 32'(gnt_idx), 32'd3);
`else
        for (int k = 1; k <= 100; k++) begin
            applyStimulus();
            if (timeout_evt) pulses++;
        end
        checkOutput("lockPulses", 32'(pulses), 32'd0);
        checkOutput("lockBusy", 32'(gnt_busy), 32'd1);
`endif

        // Random traffic against the model, with occasional async resets.
        asyncReset();
        for (int t = 0; t < 2000; t++) begin
            if ($urandom_range(0, 3) == 0) req = randomReq();
            gnt_ready = 1'($urandom_range(0, 1));
            rel = ($urandom_range(0, 3) == 0);
            if ($urandom_range(0, 399) == 0) asyncReset();
            else applyStimulus();
        end

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
